// File: rtl/sc_arith_engine.sv
// Stochastic-computing arithmetic engine: LFSR-driven bitstreams, four operators,
// ones counted over a 2^LOG_LEN window and scaled to a WIDTH-bit result.
module sc_arith_engine #(
  parameter int WIDTH   = 9,
  parameter int LOG_LEN = 17,
  parameter int LFSR_W  = 31,
  parameter int TAP     = 27,
  parameter int SEED    = 1349395
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             sat
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [LFSR_W-1:0] SEED_V = LFSR_W'(SEED);

  state_t             state, state_next;
  logic [WIDTH-1:0]   op_a_r, op_b_r;
  logic [1:0]         mode_r;
  logic [LFSR_W-1:0]  lfsr;
  logic [LOG_LEN:0]   ones;
  logic [LOG_LEN-1:0] cyc;
  logic               d_r;

  logic               a_bit, b_bit, sel, o_bit, fb, last;
  logic [LOG_LEN:0]   final_cnt;

  assign a_bit = (lfsr[WIDTH-1:0] < op_a_r);
  assign b_bit = (lfsr[2*WIDTH+2:WIDTH+3] < op_b_r);
  assign sel   = lfsr[LFSR_W-1];
  assign fb    = lfsr[LFSR_W-1] ^ lfsr[TAP];
  assign last  = (cyc == '1);

  always_comb begin
    o_bit = 1'b0;
    case (mode_r)
      2'd0: o_bit = ~(a_bit ^ b_bit);
      2'd1: o_bit = a_bit & b_bit;
      2'd2: o_bit = sel ? b_bit : a_bit;
      2'd3: o_bit = ~(a_bit ^ d_r);
      default: o_bit = 1'b0;
    endcase
  end

  // Count is one bit wider than the window so the all-ones case is visible.
  assign final_cnt = ones + {{LOG_LEN{1'b0}}, o_bit};

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = RUN;
      RUN:  if (abort || last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      op_a_r <= '0;
      op_b_r <= '0;
      mode_r <= '0;
      lfsr   <= SEED_V;
      ones   <= '0;
      cyc    <= '0;
      d_r    <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      sat    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_a_r <= op_a;
            op_b_r <= op_b;
            mode_r <= mode;
            lfsr   <= SEED_V;
            ones   <= '0;
            cyc    <= '0;
            d_r    <= 1'b0;
            busy   <= 1'b1;
          end
        end
        RUN: begin
          lfsr <= {lfsr[LFSR_W-2:0], fb};
          ones <= final_cnt;
          cyc  <= cyc + 1'b1;
          d_r  <= a_bit;
          // Abort wins over completion and leaves result/sat untouched.
          if (abort) begin
            busy <= 1'b0;
          end else if (last) begin
            busy <= 1'b0;
            done <= 1'b1;
            if (final_cnt[LOG_LEN]) begin
              result <= '1;
              sat    <= 1'b1;
            end else begin
              result <= final_cnt[LOG_LEN-1 -: WIDTH];
              sat    <= 1'b0;
            end
          end
        end
        default: busy <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_sc_arith_engine.sv
// Scoreboard bench for sc_arith_engine using a shortened 2^10-cycle window.
module tb_sc_arith_engine;

  localparam int WIDTH   = 9;
  localparam int LOG_LEN = 10;
  localparam int LEN     = 1 << LOG_LEN;
  localparam int LIMIT   = LEN + 50;
  localparam logic [30:0] SEED = 31'd1349395;

  typedef struct packed {
    logic       sat;
    logic [8:0] res;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [1:0]       mode = 2'd0;
  logic [WIDTH-1:0] op_a = '0;
  logic [WIDTH-1:0] op_b = '0;
  logic             busy, done, sat;
  logic [WIDTH-1:0] result;

  int   n_cmp = 0;
  int   n_fail = 0;
  int   n_done = 0;
  exp_t sb[$];

  sc_arith_engine #(
    .WIDTH(WIDTH), .LOG_LEN(LOG_LEN), .LFSR_W(31), .TAP(27), .SEED(1349395)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mode(mode),
    .op_a(op_a), .op_b(op_b), .busy(busy), .done(done), .result(result), .sat(sat)
  );

  always #5 clk = ~clk;

  // Reference: bit-level walk of the LFSR and operators over the whole window.
  function automatic exp_t model(input logic [1:0] m, input logic [8:0] a, input logic [8:0] b);
    logic [30:0] l;
    int   cnt;
    logic ab, bb, s, o, d;
    exp_t e;
    l = SEED; cnt = 0; d = 1'b0;
    for (int i = 0; i < LEN; i++) begin
      ab = (l[8:0] < a);
      bb = (l[20:12] < b);
      s  = l[30];
      case (m)
        2'd0: o = ~(ab ^ bb);
        2'd1: o = ab & bb;
        2'd2: o = s ? bb : ab;
        default: o = ~(ab ^ d);
      endcase
      cnt += int'(o);
      d = ab;
      l = {l[29:0], l[30] ^ l[27]};
    end
    if (cnt == LEN) begin
      e.sat = 1'b1; e.res = 9'h1FF;
    end else begin
      e.sat = 1'b0; e.res = 9'((cnt >> (LOG_LEN - WIDTH)) & 32'h1FF);
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (done) begin
      n_done++;
      n_cmp++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected_done: result=%h sat=%b with no pending start", result, sat);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (result !== e.res || sat !== e.sat) begin
          n_fail++;
          $display("FAIL sb_result: got result=%h sat=%b, expected result=%h sat=%b",
                   result, sat, e.res, e.sat);
        end
      end
    end
  end

  // Caller is just past a posedge; start is sampled on the next edge.
  task automatic pulse_start(input logic [1:0] m, input logic [8:0] a, input logic [8:0] b,
                             input bit push);
    mode = m; op_a = a; op_b = b; start = 1'b1;
    if (push) sb.push_back(model(m, a, b));
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (n < LIMIT) begin
      @(posedge clk); #1;
      n++;
      if (done) break;
    end
  endtask

  task automatic check_latency(input string name, input int n);
    n_cmp++;
    if (n !== LEN) begin
      n_fail++;
      $display("FAIL %s: done after %0d edges, expected %0d", name, n, LEN);
    end
  endtask

  task automatic run_op(input string name, input logic [1:0] m, input logic [8:0] a,
                        input logic [8:0] b);
    int n;
    pulse_start(m, a, b, 1'b1);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_busy: busy=%b after start, expected 1", name, busy);
    end
    wait_done(n);
    check_latency(name, n);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({busy, done, sat, result} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_state: busy=%b done=%b sat=%b result=%h, expected all 0",
               busy, done, sat, result);
    end
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_constants();
    run_op("bipolar_mul_zero", 2'd0, 9'h000, 9'h000);
    n_cmp++;
    if (result !== 9'h1FF || sat !== 1'b1) begin
      n_fail++;
      $display("FAIL bipolar_mul_zero_sat: result=%h sat=%b, expected 1ff/1", result, sat);
    end
    run_op("unipolar_mul_zero", 2'd1, 9'h000, 9'h1FF);
    run_op("scaled_add_zero", 2'd2, 9'h000, 9'h000);
    run_op("square_zero", 2'd3, 9'h000, 9'h155);
  endtask

  task automatic test_model();
    logic [1:0] ms[6] = '{2'd1, 2'd0, 2'd2, 2'd3, 2'd0, 2'd2};
    logic [8:0] as[6] = '{9'h100, 9'h0C3, 9'h1F0, 9'h17A, 9'h1FF, 9'h055};
    logic [8:0] bs[6] = '{9'h100, 9'h12D, 9'h010, 9'h000, 9'h1FF, 9'h1AA};
    for (int i = 0; i < 6; i++) begin
      run_op("model_op", ms[i], as[i], bs[i]);
      if (i == 0) begin
        n_cmp++;
        if (result < 9'h07C || result > 9'h084) begin
          n_fail++;
          $display("FAIL unipolar_half_range: result=%h, expected 080 +/- 4", result);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int n;
    pulse_start(2'd1, 9'h0F0, 9'h180, 1'b1);
    n = 0;
    while (n < LIMIT) begin
      @(posedge clk); #1;
      n++;
      if (n == 10 || n == 40) begin
        start = 1'b1; mode = 2'd3; op_a = 9'h000; op_b = 9'h000;
      end else begin
        start = 1'b0;
      end
      if (done) break;
    end
    start = 1'b0;
    check_latency("start_while_busy", n);
    // done is high right now: a start in this cycle must be accepted.
    pulse_start(2'd2, 9'h033, 9'h1C4, 1'b1);
    wait_done(n);
    check_latency("start_on_done", n);
    @(negedge clk);
  endtask

  task automatic test_abort();
    int d0;
    run_op("abort_prep", 2'd0, 9'h000, 9'h000);
    pulse_start(2'd1, 9'h000, 9'h000, 1'b0);
    repeat (19) @(posedge clk);
    #1; abort = 1'b1;
    @(posedge clk); #1; abort = 1'b0;
    d0 = n_done;
    n_cmp++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_busy: busy=%b, expected 0", busy);
    end
    repeat (LEN + 20) @(posedge clk);
    #1;
    n_cmp++;
    if (n_done !== d0 || result !== 9'h1FF || sat !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_hold: dones=%0d result=%h sat=%b, expected %0d/1ff/1",
               n_done, result, sat, d0);
    end
    // Abort on the completion edge itself.
    pulse_start(2'd2, 9'h000, 9'h000, 1'b0);
    repeat (LEN - 1) @(posedge clk);
    #1; abort = 1'b1;
    @(posedge clk); #1; abort = 1'b0;
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_at_completion: done=%b busy=%b, expected 0/0", done, busy);
    end
    repeat (5) @(posedge clk);
    #1;
    n_cmp++;
    if (n_done !== d0 || result !== 9'h1FF) begin
      n_fail++;
      $display("FAIL abort_at_completion_hold: dones=%0d result=%h, expected %0d/1ff",
               n_done, result, d0);
    end
  endtask

  task automatic test_reset_mid_run();
    pulse_start(2'd0, 9'h000, 9'h000, 1'b0);
    repeat (29) @(posedge clk);
    #3; rst_n = 1'b1;
    #2;
    n_cmp++;
    if ({busy, done, sat, result} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_mid_run: busy=%b done=%b sat=%b result=%h, expected all 0",
               busy, done, sat, result);
    end
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #1;
    run_op("after_reset", 2'd1, 9'h000, 9'h000);
  endtask

  initial begin
    test_reset();
    test_constants();
    test_model();
    test_back_to_back();
    test_abort();
    test_reset_mid_run();
    repeat (5) @(posedge clk);
    n_cmp++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: %0d results never produced, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/sc_arith_engine.md
Name: sc_arith_engine

Overview:
Parametrised stochastic-computing arithmetic engine, replacing the fixed 9-bit serial-in/serial-out datapath.
- Operands are loaded in parallel with a start/busy/done handshake.
- An internal Fibonacci LFSR converts the operands to stochastic bitstreams.
- One of four selectable operators is applied: bipolar multiply, unipolar multiply, scaled add, bipolar square.
- Output ones are counted over a 2^LOG_LEN-cycle window and a WIDTH-bit result is returned.
- Sits between the host register interface and the stochastic-compute test harness.

Parameters:
- WIDTH, 9: operand/result width in bits.
- LOG_LEN, 17: log2 of stream length. Constraint: LOG_LEN >= WIDTH.
- LFSR_W, 31: LFSR length. Constraint: LFSR_W >= 2*WIDTH+4.
- TAP, 27: second feedback tap index. Feedback is lfsr[LFSR_W-1] ^ lfsr[TAP].
- SEED, 1349395: LFSR load value. Must be nonzero.

Ports:
- clk, in, 1: clock.
- rst_n, in, 1: reset.
- start, in, 1: request a new computation; sampled only in IDLE.
- abort, in, 1: cancel the computation in progress.
- mode, in, 2: 0 = bipolar mul, 1 = unipolar mul, 2 = scaled add, 3 = bipolar square.
- op_a, in, WIDTH: operand A.
- op_b, in, WIDTH: operand B; ignored in mode 3.
- busy, out, 1: computation in progress.
- done, out, 1: one-cycle pulse when result is updated.
- result, out, WIDTH: last completed result.
- sat, out, 1: last result was saturated.

Behaviour:
- Reset: rst_n is asynchronous, active-high; clock clk.
  - state = IDLE; busy, done, sat = 0; result = 0.
  - lfsr = SEED; ones counter, cycle counter and square-delay flop = 0.
  - Reset mid-RUN discards the computation; no done is generated.
- FSM states: IDLE, RUN.
- IDLE -> RUN: at an edge where start = 1.
  - Latch op_a, op_b and mode into registers.
  - lfsr <= SEED; ones <= 0; cyc <= 0; delay flop <= 0; busy <= 1.
- RUN, each edge:
  - Form bits from the current lfsr:
    - a = (lfsr[WIDTH-1:0] < op_a_r)
    - b = (lfsr[2*WIDTH+2:WIDTH+3] < op_b_r)
    - sel = lfsr[LFSR_W-1]
  - Operator output o, by mode:
    - mode 0: o = ~(a ^ b)
    - mode 1: o = a & b
    - mode 2: o = sel ? b : a
    - mode 3: o = ~(a ^ d), where d is a registered one cycle earlier (d = 0 on the first RUN cycle).
  - ones <= ones + o (LOG_LEN+1 bits, never wraps).
  - lfsr shifts left, new bit 0 = feedback.
  - cyc <= cyc + 1.
- Completion: the edge where cyc == 2^LOG_LEN - 1 accumulates the final bit, then:
  - State -> IDLE; busy <= 0; done <= 1 for exactly one cycle.
  - Final count F = ones + o.
  - result <= F[LOG_LEN-1:LOG_LEN-WIDTH] when F < 2^LOG_LEN; sat <= 0.
  - result <= all ones when F == 2^LOG_LEN; sat <= 1.
- Latency: start sampled at edge E0; done high after edge E0 + 2^LOG_LEN; busy high from E0 until that edge.
- start while busy: ignored. Operand or mode changes during RUN have no effect.
- start high in the cycle done is high: accepted (state is already IDLE).
- abort in RUN: state -> IDLE, busy <= 0, no done; result and sat unchanged. Abort has priority over completion on the same edge. abort in IDLE: no effect.
- Outputs hold their value between computations. done never asserts without a preceding accepted start.

Test Plan:
- WIDTH=9, LOG_LEN=17: mode 0, op_a = 0, op_b = 0 -> o = 1 on every cycle; done after exactly 131072 edges past start; result = 0x1FF; sat = 1.
- Mode 1, op_a = 0, op_b = 0x1FF -> result = 0, sat = 0; mode 2 with op_a = op_b = 0 -> result = 0.
- Mode 3, op_a = 0 -> result = 0x1FF, sat = 1. Then mode 1, op_a = op_b = 0x100 -> result bit-exact vs C model of LFSR/operators, and within 0x080 ± 4.
- Small config WIDTH=4, LOG_LEN=6: start pulse then a second start at cycles 10 and 40 -> only one done, at edge 64 after first start; next start on the done cycle accepted, second done 64 edges later.
- abort at RUN cycle 20 with previous result 0x1FF -> busy falls, no done, result stays 0x1FF; abort and completion on the same edge -> no done.
- Assert rst_n at RUN cycle 30, release, start mode 1 op_a = op_b = 0 -> busy, done, result, sat all 0 after reset; the new run completes normally with result = 0.
